// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO in front of the 8-bit registered ALU.
// Commands are queued over a valid/ready handshake and issued one per clock.
// Issue is free-running while run is high, or one per step rising edge while run is low.
// When nothing is issued, the hold opcode is driven so the ALU register keeps its value.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned FUNC_W = 3,
  parameter logic [FUNC_W-1:0] IDLE_FUNC = 3'b111
) (
  input  logic                       Clock,
  input  logic                       Reset_b,
  input  logic                       cmd_valid,
  input  logic [DATA_W-1:0]          cmd_data,
  input  logic [FUNC_W-1:0]          cmd_func,
  output logic                       cmd_ready,
  input  logic                       run,
  input  logic                       step,
  output logic [DATA_W-1:0]          Data,
  output logic [FUNC_W-1:0]          Function,
  output logic                       issue,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_step_q;
  logic              w_step_edge;
  logic              w_push;
  logic              w_pop;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [FUNC_W-1:0] r_mem_func [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_empty;
  logic              r_full;

  logic [DATA_W-1:0] r_data;
  logic [FUNC_W-1:0] r_func;
  logic              r_issue;

  assign w_step_edge = step & ~r_step_q;
  assign w_push      = cmd_valid & ~r_full;

  assign cmd_ready = ~r_full;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign Data      = r_data;
  assign Function  = r_func;
  assign issue     = r_issue;

  // Mode state register
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next mode and pop decision; a change of run applies to this cycle's pop
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt = ST_RUN;
          w_pop       = ~r_empty;
        end else begin
          w_pop = w_step_edge & ~r_empty;
        end
      end
      ST_RUN: begin
        if (!run) begin
          w_state_nxt = ST_IDLE;
          w_pop       = w_step_edge & ~r_empty;
        end else begin
          w_pop = ~r_empty;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Step edge detector history
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) r_step_q <= 1'b0;
    else          r_step_q <= step;
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers and occupancy flags
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  // Payload storage; contents are don't-care until written
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= cmd_data;
      r_mem_func[r_wr_ptr] <= cmd_func;
    end
  end

  // ALU-facing output register: popped command or hold opcode
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      r_data  <= '0;
      r_func  <= IDLE_FUNC;
      r_issue <= 1'b0;
    end else if (w_pop) begin
      r_data  <= r_mem_data[r_rd_ptr];
      r_func  <= r_mem_func[r_rd_ptr];
      r_issue <= 1'b1;
    end else begin
      r_data  <= '0;
      r_func  <= IDLE_FUNC;
      r_issue <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed table, hand sequences, and
// randomized traffic against a queue-based reference model.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       Clock;
  logic       Reset_b;
  logic       cmd_valid;
  logic [3:0] cmd_data;
  logic [2:0] cmd_func;
  logic       cmd_ready;
  logic       run;
  logic       step;
  logic [3:0] Data;
  logic [2:0] Function;
  logic       issue;
  logic [2:0] count;
  logic       empty;
  logic       full;

  int n_cmp = 0;
  int n_bad = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(4), .FUNC_W(3), .IDLE_FUNC(3'b111)) dut (
    .Clock(Clock), .Reset_b(Reset_b),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_func(cmd_func), .cmd_ready(cmd_ready),
    .run(run), .step(step),
    .Data(Data), .Function(Function), .issue(issue),
    .count(count), .empty(empty), .full(full)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: a queue of pending commands plus the previous step level
  typedef struct packed {
    logic [3:0] d;
    logic [2:0] f;
  } ent_t;

  ent_t       mq[$];
  logic       m_step_prev;
  logic       m_issue;
  logic [3:0] m_data;
  logic [2:0] m_func;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_step_prev = 1'b0;
    m_issue     = 1'b0;
    m_data      = 4'd0;
    m_func      = 3'b111;
  endtask

  // Commands go out in arrival order; run issues whenever something is queued,
  // otherwise only a fresh step press does. Push is judged on occupancy before the pop.
  task automatic model_edge();
    ent_t e;
    bit   do_pop;
    bit   do_push;
    do_pop  = (mq.size() > 0) && (run || (step && !m_step_prev));
    do_push = cmd_valid && (mq.size() < DEPTH);
    if (do_pop) begin
      e       = mq.pop_front();
      m_issue = 1'b1;
      m_data  = e.d;
      m_func  = e.f;
    end else begin
      m_issue = 1'b0;
      m_data  = 4'd0;
      m_func  = 3'b111;
    end
    if (do_push) mq.push_back({cmd_data, cmd_func});
    m_step_prev = step;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".issue"}, 32'(issue), 32'(m_issue));
    chk({tag, ".data"},  32'(Data), 32'(m_data));
    chk({tag, ".func"},  32'(Function), 32'(m_func));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(mq.size() < DEPTH));
  endtask

  // Apply inputs for one cycle, clock it, advance the model, sample 1 time unit later
  task automatic drive_cycle(input logic v, input logic [3:0] d, input logic [2:0] f,
                             input logic r, input logic s);
    cmd_valid = v;
    cmd_data  = d;
    cmd_func  = f;
    run       = r;
    step      = s;
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [2:0] f;
    logic       r;
    logic       s;
    logic       e_issue;
    logic [3:0] e_d;
    logic [2:0] e_f;
    int         e_cnt;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] seen[$];

  initial begin
    // Fill to full, reject a fifth push, then drain in run mode
    tbl[0] = '{1'b1, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 3'b111, 1};
    tbl[1] = '{1'b1, 4'd2, 3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 3'b111, 2};
    tbl[2] = '{1'b1, 4'd3, 3'b110, 1'b0, 1'b0, 1'b0, 4'd0, 3'b111, 3};
    tbl[3] = '{1'b1, 4'd4, 3'b101, 1'b0, 1'b0, 1'b0, 4'd0, 3'b111, 4};
    tbl[4] = '{1'b1, 4'd5, 3'b010, 1'b0, 1'b0, 1'b0, 4'd0, 3'b111, 4};
    tbl[5] = '{1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 4'd1, 3'b000, 3};
    tbl[6] = '{1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 4'd2, 3'b001, 2};
    tbl[7] = '{1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 4'd3, 3'b110, 1};
    tbl[8] = '{1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 4'd4, 3'b101, 0};
    tbl[9] = '{1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0, 3'b111, 0};

    Reset_b   = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 4'd0;
    cmd_func  = 3'd0;
    run       = 1'b0;
    step      = 1'b0;
    model_reset();
    #12;
    chk("rst.data",  32'(Data), 32'd0);
    chk("rst.func",  32'(Function), 32'd7);
    chk("rst.issue", 32'(issue), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    Reset_b = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      drive_cycle(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r, tbl[i].s);
      chk($sformatf("tbl%0d.issue", i), 32'(issue), 32'(tbl[i].e_issue));
      chk($sformatf("tbl%0d.data", i),  32'(Data), 32'(tbl[i].e_d));
      chk($sformatf("tbl%0d.func", i),  32'(Function), 32'(tbl[i].e_f));
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.full", i),  32'(full), 32'(tbl[i].e_cnt == 4));
      chk($sformatf("tbl%0d.ready", i), 32'(cmd_ready), 32'(tbl[i].e_cnt != 4));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
    end

    // Single-step: held step issues once, a new press issues again, a press while empty is lost
    drive_cycle(1'b1, 4'd6, 3'b011, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd7, 3'b100, 1'b0, 1'b0);
    chk("step.count2", 32'(count), 32'd2);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    chk("step.hold1.issue", 32'(issue), 32'd1);
    chk("step.hold1.data",  32'(Data), 32'd6);
    chk("step.hold1.func",  32'(Function), 32'd3);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    chk("step.hold2.issue", 32'(issue), 32'd0);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    chk("step.hold3.issue", 32'(issue), 32'd0);
    chk("step.hold3.count", 32'(count), 32'd1);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    chk("step.low.issue", 32'(issue), 32'd0);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    chk("step.second.issue", 32'(issue), 32'd1);
    chk("step.second.data",  32'(Data), 32'd7);
    chk("step.second.func",  32'(Function), 32'd4);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    chk("step.empty.issue", 32'(issue), 32'd0);
    chk("step.empty.func",  32'(Function), 32'd7);
    drive_cycle(1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    check_model("step.end");

    // Streaming in run mode: ten back-to-back pushes, pointers wrap
    seen.delete();
    for (int i = 0; i < 12; i++) begin
      drive_cycle(i < 10, 4'(i), 3'(i), 1'b1, 1'b0);
      check_model($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.cnt_le1", i), 32'(count <= 3'd1), 32'd1);
      if (issue) seen.push_back(Data);
    end
    chk("wrap.n_issued", 32'(seen.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen.size(); i++)
      chk($sformatf("wrap.order%0d", i), 32'(seen[i]), 32'(i));

    // Reset in mid-stream discards the queue
    drive_cycle(1'b1, 4'd8,  3'b001, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd9,  3'b010, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd10, 3'b011, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'd0,  3'd0,   1'b1, 1'b0);
    chk("mid.first.issue", 32'(issue), 32'd1);
    chk("mid.first.data",  32'(Data), 32'd8);
    Reset_b = 1'b0;
    model_reset();
    #1;
    chk("mid.rst.data",  32'(Data), 32'd0);
    chk("mid.rst.func",  32'(Function), 32'd7);
    chk("mid.rst.issue", 32'(issue), 32'd0);
    chk("mid.rst.count", 32'(count), 32'd0);
    chk("mid.rst.empty", 32'(empty), 32'd1);
    chk("mid.rst.ready", 32'(cmd_ready), 32'd1);
    #2;
    Reset_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 4'd0, 3'd0, 1'b1, 1'b0);
      chk($sformatf("mid.after%0d.issue", i), 32'(issue), 32'd0);
      chk($sformatf("mid.after%0d.count", i), 32'(count), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
